lu_serial_engine: RTL and testbench

//  Bit-serial driver/collector for the OR/NOR logic-unit slice: latches two WIDTH-bit

---
 rtl/lu_pkg.sv | 17 +
 rtl/lu_serial_engine_if.sv | 50 +++++
 rtl/lu_serial_engine_bit_slice.sv | 20 ++
 rtl/lu_serial_engine.sv | 137 +++++++++++++
 tb/tb_lu_serial_engine.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lu_pkg.sv
// Shared types and constants for the bit-serial OR/NOR logic-unit engine.
// Contents:
//   lu_state_t  - engine FSM state (IDLE, SHIFT, DONE)
//   LU_OP_OR    - op select value for OR
//   LU_OP_NOR   - op select value for NOR
package lu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } lu_state_t;

    localparam logic LU_OP_OR  = 1'b0;
    localparam logic LU_OP_NOR = 1'b1;

endpackage

// File: rtl/lu_serial_engine_if.sv
// Start/done handshake and operand/result bus of the bit-serial logic unit.
// Signals:
//   start           request from the operand path, taken only while ready=1
//   a, b [WIDTH]    operands, captured on an accepted start
//   sel             0: OR, 1: NOR, captured on an accepted start
//   ready           engine can accept a start this cycle
//   busy            engine is shifting
//   done            one-cycle pulse, result just updated
//   result [WIDTH]  last completed result
//   parity          XOR-reduce of result (only when LU_PARITY_EN is defined)
// Modports: master = operand source / result consumer, slave = engine.
interface lu_serial_engine_if #(
    parameter int unsigned WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
`ifdef LU_PARITY_EN
    logic             parity;
`endif

`ifdef LU_PARITY_EN
    modport master (
        output start, a, b, sel,
        input  ready, busy, done, result, parity
    );

    modport slave (
        input  start, a, b, sel,
        output ready, busy, done, result, parity
    );
`else
    modport master (
        output start, a, b, sel,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, a, b, sel,
        output ready, busy, done, result
    );
`endif

endinterface

// File: rtl/lu_serial_engine_bit_slice.sv
// One-bit OR/NOR logic-unit slice (purely combinational).
// Ports:
//   a_i, b_i  operand bits
//   sel_i     LU_OP_OR or LU_OP_NOR
//   y_o       a_i|b_i, inverted when sel_i selects NOR
module lu_bit_slice
    import lu_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic sel_i,
    output logic y_o
);

    logic or_c;

    assign or_c = a_i | b_i;
    assign y_o  = (sel_i == LU_OP_NOR) ? ~or_c : or_c;

endmodule

// File: rtl/lu_serial_engine.sv
// Bit-serial driver/collector for the OR/NOR logic-unit slice. Captures two
// WIDTH-bit operands and an op select, feeds one bit pair per clock through
// lu_bit_slice (LSB first) and reassembles the serial results into a word.
// One operation takes WIDTH SHIFT cycles plus one DONE cycle; a start seen in
// DONE begins the next operation with no idle gap.
// Ports:
//   clk    clock, rising edge
//   reset  synchronous, active-high
//   bus    lu_serial_engine_if.slave (start/a/b/sel in; ready/busy/done/result out)
// Build option:
//   LU_PARITY_EN  adds bus.parity, a register holding ^result.
module lu_serial_engine
    import lu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    lu_serial_engine_if.slave   bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    lu_state_t        state_q;
    lu_state_t        state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sel_q;
    logic [WIDTH-2:0] acc_q;       // upper WIDTH-1 bits of the word being assembled
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] cnt_q;

    logic             bit_c;
    logic             last_c;
    logic             load_c;
    logic             ready_c;
    logic             busy_c;
    logic             done_c;
    logic [WIDTH-1:0] word_c;

    // Serial slice always looks at the LSBs of the captured operands.
    lu_bit_slice u_slice (
        .a_i   (a_q[0]),
        .b_i   (b_q[0]),
        .sel_i (sel_q),
        .y_o   (bit_c)
    );

    assign last_c = (cnt_q == CNT_LAST);
    assign word_c = {bit_c, acc_q};
    assign load_c = ready_c & bus.start;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (last_c)    state_d = DONE;
            DONE:    state_d = bus.start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        ready_c = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            IDLE:  ready_c = 1'b1;
            SHIFT: busy_c  = 1'b1;
            DONE: begin
                ready_c = 1'b1;
                done_c  = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand capture, serial shift, counter and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else if (load_c) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            sel_q <= bus.sel;
            cnt_q <= '0;
        end else if (busy_c) begin
            acc_q <= word_c[WIDTH-1:1];
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            if (last_c) begin
                result_q <= word_c;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef LU_PARITY_EN
    logic parity_q;

    // Parity tracks the result register edge for edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (busy_c && last_c) begin
            parity_q <= ^word_c;
        end
    end

    assign bus.parity = parity_q;
`endif

    assign bus.ready  = ready_c;
    assign bus.busy   = busy_c;
    assign bus.done   = done_c;
    assign bus.result = result_q;

endmodule

// File: tb/tb_lu_serial_engine.sv
// Self-checking bench for lu_serial_engine (WIDTH=8): table of operations plus
// hand-written sequences for start-while-busy, streaming, and reset corners.
// Expected results are queued when an operation is launched and compared when
// the engine pulses done.
module tb_lu_serial_engine;

    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sel;
        logic [WIDTH-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    lu_serial_engine_if #(.WIDTH(WIDTH)) bus ();

    lu_serial_engine #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic sel);
        return sel ? ~(a | b) : (a | b);
    endfunction

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done actual=%0h required=none", bus.result);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                check("result", 32'(bus.result), 32'(e));
`ifdef LU_PARITY_EN
                check("parity", 32'(bus.parity), 32'(^e));
`endif
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) check("ready_timeout", 32'(bus.ready), 32'd1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 50);
        if (!bus.done) check("done_timeout", 32'(n), 32'd9);
    endtask

    // Launch one op, then measure start-to-done latency and busy length.
    task automatic op_timed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic sel, input logic [WIDTH-1:0] exp);
        int lat;
        int busy_cycles;
        wait_ready();
        @(posedge clk); #1;
        bus.a = a;
        bus.b = b;
        bus.sel = sel;
        bus.start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_cycles++;
        end while (!bus.done && lat < 50);
        check("latency", 32'(lat), 32'd9);
        check("busy_cycles", 32'(busy_cycles), 32'd8);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        vec_t vecs[8];
        int d0;
        int gap;

        vecs[0] = '{a: 8'hA5, b: 8'h0F, sel: 1'b0, exp: 8'hAF};
        vecs[1] = '{a: 8'hA5, b: 8'h0F, sel: 1'b1, exp: 8'h50};
        vecs[2] = '{a: 8'hFF, b: 8'h00, sel: 1'b0, exp: 8'hFF};
        vecs[3] = '{a: 8'h00, b: 8'h00, sel: 1'b1, exp: 8'hFF};
        vecs[4] = '{a: 8'h12, b: 8'h40, sel: 1'b0, exp: 8'h52};
        vecs[5] = '{a: 8'h81, b: 8'h18, sel: 1'b1, exp: 8'h66};
        for (int i = 6; i < 8; i++) begin
            vecs[i].a   = 8'($urandom);
            vecs[i].b   = 8'($urandom);
            vecs[i].sel = 1'($urandom);
            vecs[i].exp = model(vecs[i].a, vecs[i].b, vecs[i].sel);
        end

        reset = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
`ifdef LU_PARITY_EN
        check("rst_parity", 32'(bus.parity), 32'd0);
`endif

        // Table of single operations (first two are the OR/NOR reference pair).
        for (int i = 0; i < 8; i++) begin
            op_timed(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp);
        end

        // Start re-pulsed mid-SHIFT must be ignored.
        wait_ready();
        @(posedge clk); #1;
        bus.a = 8'hFF;
        bus.b = 8'h00;
        bus.sel = 1'b1;
        bus.start = 1'b1;
        exp_q.push_back(8'h00);
        @(posedge clk); #1;
        bus.start = 1'b0;
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        bus.a = 8'h00;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        check("busy_start_dones", 32'(done_cnt - d0), 32'd1);

        // Start held high: four back-to-back ops with sel toggling.
        @(posedge clk); #1;
        bus.a = 8'h0F;
        bus.b = 8'hF0;
        bus.sel = 1'b0;
        bus.start = 1'b1;
        exp_q.push_back(8'hFF);
        @(posedge clk); #1;
        bus.sel = 1'b1;
        exp_q.push_back(8'h00);
        for (int i = 0; i < 4; i++) begin
            wait_done(gap);
            check("stream_gap", 32'(gap), 32'd9);
            @(posedge clk); #1;
            if (i < 3) begin
                check("stream_no_idle", 32'(bus.busy), 32'd1);
                if (i + 2 < 4) begin
                    bus.sel = ~bus.sel;
                    exp_q.push_back(((i + 2) % 2 == 0) ? 8'hFF : 8'h00);
                end else begin
                    bus.start = 1'b0;
                end
            end else begin
                check("stream_end_ready", 32'(bus.ready), 32'd1);
            end
        end

        // Reset during the 4th SHIFT cycle aborts the op and clears result.
        op_timed(8'hA5, 8'h0F, 1'b0, 8'hAF);
        @(posedge clk); #1;
        bus.a = 8'h3C;
        bus.b = 8'h00;
        bus.sel = 1'b0;
        bus.start = 1'b1;
        exp_q.push_back(8'h3C);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_result_held", 32'(bus.result), 32'hAF);
        reset = 1'b1;
        exp_q.delete();
        d0 = done_cnt;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_result", 32'(bus.result), 32'd0);
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
`ifdef LU_PARITY_EN
        check("abort_parity", 32'(bus.parity), 32'd0);
`endif
        repeat (12) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        op_timed(8'h3C, 8'h00, 1'b0, 8'h3C);

        // Reset and start in the same cycle: reset wins.
        @(posedge clk); #1;
        reset = 1'b1;
        bus.a = 8'hFF;
        bus.b = 8'h00;
        bus.sel = 1'b0;
        bus.start = 1'b1;
        d0 = done_cnt;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy", 32'(bus.busy), 32'd0);
        check("rst_start_ready", 32'(bus.ready), 32'd1);
        repeat (12) @(negedge clk);
        check("rst_start_no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_start_idle_busy", 32'(bus.busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
